punc_exec_unit: RTL and testbench

//  Parametrised next-generation PUnC execution datapath: accepts one micro-op per valid/ready handshake.

---
 rtl/punc_exec_unit_if.sv | 48 ++++
 rtl/punc_exec_unit.sv | 215 +++++++++++++++++++++
 tb/tb_punc_exec_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_exec_unit_if.sv
// ---------------------------------------------------------------------------
// punc_exec_unit_if
// Groups the micro-op handshake and the external memory port of the PUnC
// execution unit.
//   op_*   : micro-op offered by the fetch/decode controller (valid/ready),
//            plus the op_done retire pulse
//   mem_*  : variable-latency req/ack memory port
// Modports:
//   slave  : the execution unit (accepts ops, drives memory requests)
//   master : the controller/memory side (offers ops, answers requests)
// ---------------------------------------------------------------------------
interface punc_exec_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 9
);
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [REG_AW-1:0] op_rd;
  logic [REG_AW-1:0] op_ra;
  logic [REG_AW-1:0] op_rb;
  logic              op_use_imm;
  logic [IMM_W-1:0]  op_imm;
  logic [2:0]        op_nzp;
  logic              op_done;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  op_valid, op_code, op_rd, op_ra, op_rb, op_use_imm, op_imm, op_nzp,
    output op_ready, op_done,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output op_valid, op_code, op_rd, op_ra, op_rb, op_use_imm, op_imm, op_nzp,
    input  op_ready, op_done,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/punc_exec_unit.sv
// ---------------------------------------------------------------------------
// punc_exec_unit
// Execution datapath of the PUnC processor. Accepts one micro-op per
// valid/ready handshake and owns the register file, the PC and the NZP
// condition codes. Executes ADD/AND/NOT/LEA/BR/JMP in a single EXEC cycle and
// LD/ST through an external variable-latency memory port.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   bus         punc_exec_unit_if.slave (micro-op handshake + memory port)
//   dbg_addr_i  debug register select
//   dbg_data_o  R[dbg_addr_i], combinational
//   n_o/z_o/p_o condition codes
//   pc_o        current PC
// ---------------------------------------------------------------------------
module punc_exec_unit #(
  parameter int                DATA_W   = 16,
  parameter int                NUM_REGS = 8,
  parameter int                IMM_W    = 9,
  parameter logic [DATA_W-1:0] PC_RST   = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  punc_exec_unit_if.slave             bus,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]           dbg_data_o,
  output logic                        n_o,
  output logic                        z_o,
  output logic                        p_o,
  output logic [DATA_W-1:0]           pc_o
);

  localparam int REG_AW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_AND = 3'd1,
    OP_NOT = 3'd2,
    OP_LD  = 3'd3,
    OP_ST  = 3'd4,
    OP_LEA = 3'd5,
    OP_BR  = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  state_e            state_q;
  op_e               op_code_q;
  logic [REG_AW-1:0] op_rd_q;
  logic [REG_AW-1:0] op_ra_q;
  logic [REG_AW-1:0] op_rb_q;
  logic              op_use_imm_q;
  logic [IMM_W-1:0]  op_imm_q;
  logic [2:0]        op_nzp_q;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] pc_q;
  logic              n_q;
  logic              z_q;
  logic              p_q;

  logic              mem_we_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] acc_imm_ext;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] wr_data_d;
  logic [DATA_W-1:0] pc_d;
  logic              wr_en;
  logic              nzp_en;
  logic              retire;
  logic              taken;
  logic              accept;

  // Sign extension of the latched immediate (used at execute time) and of
  // the incoming immediate (used to form the memory address at accept time).
  assign imm_ext     = DATA_W'($signed(op_imm_q));
  assign acc_imm_ext = DATA_W'($signed(bus.op_imm));

  assign accept = bus.op_valid && (state_q == S_IDLE);

  // A memory op retires in the ack cycle itself, so op_done has to follow
  // mem_ack combinationally rather than come from a register.
  assign retire = (state_q == S_EXEC) || ((state_q == S_MEM) && bus.mem_ack);

  assign bus.op_ready  = (state_q == S_IDLE);
  assign bus.op_done   = retire;
  assign bus.mem_req   = (state_q == S_MEM);
  assign bus.mem_we    = mem_we_q && (state_q == S_MEM);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign dbg_data_o = regs_q[dbg_addr_i];
  assign pc_o       = pc_q;
  assign n_o        = n_q;
  assign z_o        = z_q;
  assign p_o        = p_q;

  // Retire-cycle datapath: works out the register write, the NZP update and
  // the next PC for whatever op is finishing this cycle.
  always_comb begin
    ra_val    = regs_q[op_ra_q];
    b_val     = op_use_imm_q ? imm_ext : regs_q[op_rb_q];
    taken     = |(op_nzp_q & {n_q, z_q, p_q});
    wr_en     = 1'b0;
    nzp_en    = 1'b0;
    wr_data_d = '0;
    pc_d      = pc_q + DATA_W'(1);

    if (state_q == S_EXEC) begin
      case (op_code_q)
        OP_ADD: begin
          wr_en     = 1'b1;
          nzp_en    = 1'b1;
          wr_data_d = ra_val + b_val;
        end
        OP_AND: begin
          wr_en     = 1'b1;
          nzp_en    = 1'b1;
          wr_data_d = ra_val & b_val;
        end
        OP_NOT: begin
          wr_en     = 1'b1;
          nzp_en    = 1'b1;
          wr_data_d = ~ra_val;
        end
        OP_LEA: begin
          wr_en     = 1'b1;
          wr_data_d = pc_q + imm_ext;
        end
        OP_BR: begin
          if (taken) pc_d = pc_q + imm_ext;
        end
        OP_JMP: begin
          pc_d = ra_val;
        end
        default: begin
        end
      endcase
    end else if ((state_q == S_MEM) && bus.mem_ack && (op_code_q == OP_LD)) begin
      wr_en     = 1'b1;
      nzp_en    = 1'b1;
      wr_data_d = bus.mem_rdata;
    end
  end

  // Control FSM, op latches, memory request registers and architectural
  // state. The memory address and store data are captured at accept; no
  // register write can happen between accept and the request cycles, so
  // this is the same value the request would see.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_code_q    <= OP_ADD;
      op_rd_q      <= '0;
      op_ra_q      <= '0;
      op_rb_q      <= '0;
      op_use_imm_q <= 1'b0;
      op_imm_q     <= '0;
      op_nzp_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pc_q         <= PC_RST;
      n_q          <= 1'b0;
      z_q          <= 1'b1;
      p_q          <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_code_q    <= op_e'(bus.op_code);
            op_rd_q      <= bus.op_rd;
            op_ra_q      <= bus.op_ra;
            op_rb_q      <= bus.op_rb;
            op_use_imm_q <= bus.op_use_imm;
            op_imm_q     <= bus.op_imm;
            op_nzp_q     <= bus.op_nzp;
            if ((bus.op_code == OP_LD) || (bus.op_code == OP_ST)) begin
              state_q     <= S_MEM;
              mem_we_q    <= (bus.op_code == OP_ST);
              mem_addr_q  <= regs_q[bus.op_ra] + acc_imm_ext;
              mem_wdata_q <= regs_q[bus.op_rb];
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: state_q <= S_IDLE;
        S_MEM: begin
          if (bus.mem_ack) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (retire) pc_q <= pc_d;
      if (wr_en) regs_q[op_rd_q] <= wr_data_d;
      if (nzp_en) begin
        n_q <= wr_data_d[DATA_W-1];
        z_q <= (wr_data_d == '0);
        p_q <= !wr_data_d[DATA_W-1] && (wr_data_d != '0);
      end
    end
  end

endmodule

// File: tb/tb_punc_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_punc_exec_unit
// Directed testbench for punc_exec_unit. An architectural model (register
// array, PC, NZP) is advanced once per retired op; a compare process checks
// the DUT against it on every falling edge, and literal expectations pin the
// model at key points of the program.
// ---------------------------------------------------------------------------
module tb_punc_exec_unit;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int IMM_W  = 9;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [REG_AW-1:0] dbgAddr = '0;
  logic [DATA_W-1:0] dbgData;
  logic [DATA_W-1:0] pcOut;
  logic              nOut, zOut, pOut;

  punc_exec_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) bus ();

  punc_exec_unit #(
    .DATA_W(DATA_W), .NUM_REGS(8), .IMM_W(IMM_W), .PC_RST(16'h0000)
  ) dut (
    .clk_i(clk), .rst_ni(rstN), .bus(bus),
    .dbg_addr_i(dbgAddr), .dbg_data_o(dbgData),
    .n_o(nOut), .z_o(zOut), .p_o(pOut), .pc_o(pcOut)
  );

  always #5 clk = ~clk;

  // Architectural model and per-cycle expectations
  logic [DATA_W-1:0] mRegs [8];
  logic [DATA_W-1:0] mPc;
  logic              mN, mZ, mP;
  logic              expReady, expDone, expReq, expWe;
  logic [DATA_W-1:0] expAddr, expWdata;
  logic              chkEn = 1'b0;
  int                errors = 0;
  int                checks = 0;
  int                reqCount = 0;
  logic [DATA_W-1:0] lastAddr, lastWdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
    return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  task automatic setFlags(input logic [DATA_W-1:0] r);
    mN = r[DATA_W-1];
    mZ = (r == 0);
    mP = !mN && !mZ;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mRegs[i] = '0;
    mPc = 16'h0000;
    mN = 1'b0; mZ = 1'b1; mP = 1'b0;
    expReady = 1'b1; expDone = 1'b0; expReq = 1'b0; expWe = 1'b0;
    expAddr = '0; expWdata = '0;
  endtask

  // Architectural effect of one retired op, straight from the ISA rules.
  task automatic modelRetire(input logic [2:0] code, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic useImm, input logic [8:0] imm,
                             input logic [2:0] nzp, input logic [15:0] rdata);
    logic [15:0] b, res;
    b = useImm ? sext(imm) : mRegs[rb];
    res = '0;
    case (code)
      3'd0: begin res = mRegs[ra] + b; mRegs[rd] = res; setFlags(res); mPc = mPc + 1; end
      3'd1: begin res = mRegs[ra] & b; mRegs[rd] = res; setFlags(res); mPc = mPc + 1; end
      3'd2: begin res = ~mRegs[ra];    mRegs[rd] = res; setFlags(res); mPc = mPc + 1; end
      3'd3: begin mRegs[rd] = rdata; setFlags(rdata); mPc = mPc + 1; end
      3'd4: mPc = mPc + 1;
      3'd5: begin mRegs[rd] = mPc + sext(imm); mPc = mPc + 1; end
      3'd6: mPc = ((nzp & {mN, mZ, mP}) != 0) ? mPc + sext(imm) : mPc + 1;
      default: mPc = mRegs[ra];
    endcase
  endtask

  // Compare process: checks every observable output against the model.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      reqCount++;
      lastAddr  = bus.mem_addr;
      lastWdata = bus.mem_wdata;
    end
    if (chkEn) begin
      checkOutput("op_ready", bus.op_ready, expReady);
      checkOutput("op_done", bus.op_done, expDone);
      checkOutput("mem_req", bus.mem_req, expReq);
      if (expReq) begin
        checkOutput("mem_we", bus.mem_we, expWe);
        checkOutput("mem_addr", bus.mem_addr, expAddr);
        if (expWe) checkOutput("mem_wdata", bus.mem_wdata, expWdata);
      end
      checkOutput("pc_out", pcOut, mPc);
      checkOutput("nzp", {nOut, zOut, pOut}, {mN, mZ, mP});
      checkOutput("dbg_data", dbgData, mRegs[dbgAddr]);
    end
  end

  // Issues one op at posedge+1, runs it to retirement and advances the model.
  task automatic applyStimulus(input logic [2:0] code, input logic [2:0] rd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic useImm, input logic [8:0] imm,
                               input logic [2:0] nzp, input int waitCycles, input logic [15:0] rdata);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_rd = rd; bus.op_ra = ra; bus.op_rb = rb;
    bus.op_use_imm = useImm; bus.op_imm = imm; bus.op_nzp = nzp;
    dbgAddr = rd;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_code = ~code; bus.op_rd = ~rd; bus.op_ra = ~ra; bus.op_rb = ~rb;
    bus.op_use_imm = ~useImm; bus.op_imm = ~imm; bus.op_nzp = ~nzp;
    expReady = 1'b0;
    if (code == 3'd3 || code == 3'd4) begin
      expReq = 1'b1; expWe = (code == 3'd4);
      expAddr = mRegs[ra] + sext(imm); expWdata = mRegs[rb];
      repeat (waitCycles) begin @(posedge clk); #1; end
      bus.mem_ack = 1'b1; bus.mem_rdata = rdata; expDone = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0; bus.mem_rdata = 16'hDEAD;
      expReq = 1'b0;
    end else begin
      expDone = 1'b1;
      @(posedge clk); #1;
    end
    expDone = 1'b0; expReady = 1'b1;
    modelRetire(code, rd, ra, rb, useImm, imm, nzp, rdata);
  endtask

  task automatic checkReg(input string name, input logic [2:0] idx, input logic [15:0] exp);
    @(posedge clk); #1;
    dbgAddr = idx;
    #1 checkOutput(name, dbgData, exp);
  endtask

  initial begin
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_rd = '0; bus.op_ra = '0; bus.op_rb = '0;
    bus.op_use_imm = 1'b0; bus.op_imm = '0; bus.op_nzp = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    modelReset();

    // Reset state
    #12;
    checkOutput("rst pc", pcOut, 16'h0000);
    checkOutput("rst z", zOut, 1'b1);
    checkOutput("rst n", nOut, 1'b0);
    checkOutput("rst ready", bus.op_ready, 1'b1);
    checkOutput("rst mem_req", bus.mem_req, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dbgAddr = 3'(i);
      #1 checkOutput("rst reg", dbgData, 16'h0000);
    end
    rstN = 1'b1;
    @(posedge clk); #1;
    chkEn = 1'b1;

    // ALU ops with immediates
    applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h1FF, 3'b000, 0, 16'h0);
    checkOutput("ADD n", nOut, 1'b1);
    applyStimulus(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 9'h000, 3'b000, 0, 16'h0);
    checkOutput("AND z", zOut, 1'b1);
    applyStimulus(3'd2, 3'd3, 3'd2, 3'd0, 1'b0, 9'h000, 3'b000, 0, 16'h0);
    checkOutput("NOT n", nOut, 1'b1);
    checkOutput("pc after 3", pcOut, 16'h0003);
    checkReg("R1", 3'd1, 16'hFFFF);
    checkReg("R2", 3'd2, 16'h0000);
    checkReg("R3", 3'd3, 16'hFFFF);

    // Store with three wait states, then load
    @(posedge clk); #1;
    reqCount = 0;
    applyStimulus(3'd4, 3'd0, 3'd2, 3'd1, 1'b0, 9'h005, 3'b000, 3, 16'h0);
    checkOutput("ST req cycles", reqCount, 4);
    checkOutput("ST addr", lastAddr, 16'h0005);
    checkOutput("ST wdata", lastWdata, 16'hFFFF);
    applyStimulus(3'd3, 3'd4, 3'd2, 3'd0, 1'b0, 9'h005, 3'b000, 1, 16'h0007);
    checkReg("LD R4", 3'd4, 16'h0007);
    checkOutput("LD p", pOut, 1'b1);

    // Branches
    applyStimulus(3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 9'h1FE, 3'b010, 0, 16'h0);
    checkOutput("BR not taken", pcOut, 16'h0006);
    applyStimulus(3'd1, 3'd2, 3'd2, 3'd0, 1'b1, 9'h000, 3'b000, 0, 16'h0);
    applyStimulus(3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 9'h1FE, 3'b010, 0, 16'h0);
    checkOutput("BR taken", pcOut, 16'h0005);
    applyStimulus(3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 9'h1FE, 3'b000, 0, 16'h0);
    checkOutput("BR mask 000", pcOut, 16'h0006);

    // LEA and JMP
    applyStimulus(3'd5, 3'd5, 3'd0, 3'd0, 1'b0, 9'h0FF, 3'b000, 0, 16'h0);
    checkReg("LEA R5", 3'd5, 16'h0105);
    checkOutput("LEA keeps z", zOut, 1'b1);
    applyStimulus(3'd7, 3'd0, 3'd5, 3'd0, 1'b0, 9'h000, 3'b000, 0, 16'h0);
    checkOutput("JMP pc", pcOut, 16'h0105);

    // Register-mode ADD with wrap, rd==ra, single-cycle memory
    applyStimulus(3'd0, 3'd6, 3'd4, 3'd3, 1'b0, 9'h000, 3'b000, 0, 16'h0);
    checkReg("ADD wrap R6", 3'd6, 16'h0006);
    applyStimulus(3'd0, 3'd4, 3'd4, 3'd4, 1'b0, 9'h000, 3'b000, 0, 16'h0);
    checkReg("ADD rd=ra R4", 3'd4, 16'h000E);
    applyStimulus(3'd3, 3'd7, 3'd4, 3'd0, 1'b0, 9'h1FD, 3'b000, 0, 16'h8000);
    checkReg("LD 1cyc R7", 3'd7, 16'h8000);
    checkOutput("LD 1cyc n", nOut, 1'b1);

    // Stray ack while idle must do nothing
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5555;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a load that is waiting for its ack
    bus.op_valid = 1'b1; bus.op_code = 3'd3; bus.op_rd = 3'd1; bus.op_ra = 3'd0; bus.op_imm = 9'h004;
    dbgAddr = 3'd1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    expReady = 1'b0; expReq = 1'b1; expWe = 1'b0; expAddr = mRegs[0] + 16'h0004;
    @(posedge clk); #1;
    chkEn = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checkOutput("rst mid mem_req", bus.mem_req, 1'b0);
    checkOutput("rst mid ready", bus.op_ready, 1'b1);
    modelReset();
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    chkEn = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    checkReg("late ack R1", 3'd1, 16'h0000);
    checkOutput("post rst pc", pcOut, 16'h0000);

    // The unit still works after the abandoned op
    applyStimulus(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 9'h003, 3'b000, 0, 16'h0);
    checkReg("post rst ADD", 3'd1, 16'h0003);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
